// File: rtl/boss_attack_sequencer.sv
// Boss fight attack sequencer: entry delay, alternating volleys, enraged bursts with rest,
// and terminal defeat. Fire/direction strobes are registered one cycle after the frame tick.
module boss_attack_sequencer #(
    parameter int unsigned LANES         = 9,
    parameter int unsigned ENTRY_FRAMES  = 60,
    parameter int unsigned VOLLEY_PERIOD = 90,
    parameter int unsigned BURST_PERIOD  = 12,
    parameter int unsigned BURST_SHOTS   = 4,
    parameter int unsigned REST_FRAMES   = 45,
    parameter int unsigned RAGE_HITS     = 10,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             enable,
    input  logic             startOfFrame,
    input  logic             boss_hit,
    input  logic             boss_dead,
    output logic             fire_pulse,
    output logic [LANES-1:0] fire_mask,
    output logic             switch_direction_pulse,
    output logic             enraged,
    output logic [2:0]       state_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ENTRY    = 3'd1,
        S_VOLLEY   = 3'd2,
        S_BURST    = 3'd3,
        S_REST     = 3'd4,
        S_DEFEATED = 3'd5
    } state_t;

    localparam int unsigned SHOT_W = $clog2(BURST_SHOTS + 1);
    localparam int unsigned HIT_W  = $clog2(RAGE_HITS + 1);

    localparam logic [CNT_W-1:0]  ENTRY_LAST  = CNT_W'(ENTRY_FRAMES - 1);
    localparam logic [CNT_W-1:0]  VOLLEY_LAST = CNT_W'(VOLLEY_PERIOD - 1);
    localparam logic [CNT_W-1:0]  BURST_LAST  = CNT_W'(BURST_PERIOD - 1);
    localparam logic [CNT_W-1:0]  REST_LAST   = CNT_W'(REST_FRAMES - 1);
    localparam logic [SHOT_W-1:0] SHOT_LAST   = SHOT_W'(BURST_SHOTS - 1);
    localparam logic [HIT_W-1:0]  HIT_MAX     = HIT_W'(RAGE_HITS);

    function automatic logic [LANES-1:0] even_lanes();
        logic [LANES-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            m[i] = (i % 2 == 0);
        end
        return m;
    endfunction

    function automatic logic [LANES-1:0] centre_lanes();
        logic [LANES-1:0] m;
        m = '0;
        for (int unsigned i = LANES / 2 - 1; i <= LANES / 2 + 1; i++) begin
            m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [LANES-1:0] ALL_MASK    = '1;
    localparam logic [LANES-1:0] EVEN_MASK   = even_lanes();
    localparam logic [LANES-1:0] CENTRE_MASK = centre_lanes();

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [SHOT_W-1:0]  shot_cnt_q, shot_cnt_d;
    logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic               parity_q, parity_d;
    logic               fire_q, fire_d;
    logic               switch_q, switch_d;
    logic [LANES-1:0]   mask_q, mask_d;
    logic               enraged_q, enraged_d;
    logic               tick;

    assign tick = startOfFrame & enable;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            shot_cnt_q  <= '0;
            hit_cnt_q   <= '0;
            parity_q    <= 1'b0;
            fire_q      <= 1'b0;
            switch_q    <= 1'b0;
            mask_q      <= '0;
            enraged_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            shot_cnt_q  <= shot_cnt_d;
            hit_cnt_q   <= hit_cnt_d;
            parity_q    <= parity_d;
            fire_q      <= fire_d;
            switch_q    <= switch_d;
            mask_q      <= mask_d;
            enraged_q   <= enraged_d;
        end
    end

    // Death overrides everything, including a fire decision on the same tick.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        shot_cnt_d  = shot_cnt_q;
        parity_d    = parity_q;
        fire_d      = 1'b0;
        switch_d    = 1'b0;
        mask_d      = mask_q;
        if (boss_dead || state_q == S_DEFEATED) begin
            state_d = S_DEFEATED;
            mask_d  = '0;
        end else if (tick) begin
            unique case (state_q)
                S_IDLE: begin
                    state_d     = S_ENTRY;
                    frame_cnt_d = '0;
                end
                S_ENTRY: begin
                    if (frame_cnt_q == ENTRY_LAST) begin
                        state_d     = S_VOLLEY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                S_VOLLEY: begin
                    if (frame_cnt_q == VOLLEY_LAST) begin
                        fire_d      = 1'b1;
                        switch_d    = 1'b1;
                        mask_d      = parity_q ? EVEN_MASK : ALL_MASK;
                        parity_d    = ~parity_q;
                        frame_cnt_d = '0;
                        if (enraged_q) begin
                            state_d    = S_BURST;
                            shot_cnt_d = '0;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                S_BURST: begin
                    if (frame_cnt_q == BURST_LAST) begin
                        fire_d      = 1'b1;
                        mask_d      = CENTRE_MASK;
                        frame_cnt_d = '0;
                        if (shot_cnt_q == SHOT_LAST) begin
                            state_d = S_REST;
                        end else begin
                            shot_cnt_d = shot_cnt_q + 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                S_REST: begin
                    if (frame_cnt_q == REST_LAST) begin
                        state_d     = S_VOLLEY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
                default: state_d = S_DEFEATED;
            endcase
        end
    end

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        if (boss_hit && state_q != S_IDLE && state_q != S_DEFEATED && hit_cnt_q != HIT_MAX) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
        enraged_d = enraged_q | (hit_cnt_q == HIT_MAX);
    end

    always_comb begin
        fire_pulse             = fire_q;
        switch_direction_pulse = switch_q;
        fire_mask              = mask_q;
        enraged                = enraged_q;
        state_out              = state_q;
    end

endmodule
